// File: rtl/sram_controller_pkg.sv
// Shared memory-system definitions for the MEM-stage SRAM bridge.
// Holds the controller state encoding, the default data-memory base address,
// the halfword/word widths and the pipeline freeze length of one word transfer.
package sram_controller_pkg;

  localparam int unsigned DefaultBaseAddr = 1024;
  localparam int unsigned HalfWidth       = 16;
  localparam int unsigned WordWidth       = 32;
  // Cycles for which ready stays low on every word transfer.
  localparam int unsigned FreezeCycles    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StRdCap,
    StWrLoA,
    StWrLoB,
    StWrHi,
    StDone
  } state_e;

endpackage

// File: rtl/sram_controller.sv
// Bridges a 32-bit word read/write request from the MEM stage to an off-chip
// 16-bit SRAM as two halfword accesses, freezing the pipeline via ready.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   wr_en, rd_en        word write / read request, held until ready
//   address             byte address (word aligned, [1:0] ignored)
//   write_data          write word, low half goes to the even SRAM address
//   read_data           last word read (registered)
//   ready               no transfer pending, or current one completes now
//   SRAM_DQ             bidirectional SRAM data bus
//   SRAM_ADDR           SRAM halfword address
//   SRAM_*_N            SRAM controls; only WE_N toggles, the rest are tied low
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR = DefaultBaseAddr,
  parameter int unsigned SRAM_AW   = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [WordWidth-1:0] address,
  input  logic [WordWidth-1:0] write_data,
  output logic [WordWidth-1:0] read_data,
  output logic                 ready,
  inout  wire  [HalfWidth-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_WE_N
);

  state_e                 state_q, state_d;
  logic [WordWidth-1:0]   read_data_q, read_data_d;
  logic                   dq_oe;
  logic [HalfWidth-1:0]   dq_out;

  // Address map: byte offset from the data-memory base, word index in the
  // low SRAM_AW-1 bits, halfword select appended as the SRAM address LSB.
  logic [WordWidth-1:0]   byte_off;
  logic [SRAM_AW-2:0]     word_off;
  logic [SRAM_AW-1:0]     lo_addr, hi_addr;
  logic                   unused_addr_bits;

  assign byte_off         = address - WordWidth'(BASE_ADDR);
  assign word_off         = byte_off[SRAM_AW:2];
  assign lo_addr          = {word_off, 1'b0};
  assign hi_addr          = {word_off, 1'b1};
  assign unused_addr_bits = ^{byte_off[WordWidth-1:SRAM_AW+1], byte_off[1:0]};

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // Controller drives the bus only while it is writing real data.
  assign SRAM_DQ   = dq_oe ? dq_out : {HalfWidth{1'bz}};
  assign read_data = read_data_q;

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    SRAM_WE_N   = 1'b1;
    SRAM_ADDR   = '0;
    dq_oe       = 1'b0;
    dq_out      = '0;
    ready       = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = !wr_en && !rd_en;
        // Write has priority when both requests are raised.
        if (wr_en) begin
          state_d = StWrLoA;
        end else if (rd_en) begin
          state_d = StRdLo;
        end
      end
      StRdLo: begin
        SRAM_ADDR = lo_addr;
        state_d   = StRdHi;
      end
      StRdHi: begin
        // SRAM returns the halfword addressed in the previous cycle.
        SRAM_ADDR                   = hi_addr;
        read_data_d[HalfWidth-1:0]  = SRAM_DQ;
        state_d                     = StRdCap;
      end
      StRdCap: begin
        SRAM_ADDR                          = hi_addr;
        read_data_d[WordWidth-1:HalfWidth] = SRAM_DQ;
        state_d                            = StDone;
      end
      StWrLoA: begin
        // Bus turnaround: the SRAM still drives DQ this cycle, so the write it
        // performs into lo carries garbage that the next cycle overwrites.
        SRAM_ADDR = lo_addr;
        SRAM_WE_N = 1'b0;
        state_d   = StWrLoB;
      end
      StWrLoB: begin
        SRAM_ADDR = lo_addr;
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = write_data[HalfWidth-1:0];
        state_d   = StWrHi;
      end
      StWrHi: begin
        SRAM_ADDR = hi_addr;
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = write_data[WordWidth-1:HalfWidth];
        state_d   = StDone;
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural SRAM on the pins, word-level memory
// model for expected contents, directed scenarios plus randomized traffic.
module tb_sram_controller;

  localparam int unsigned Base = 1024;
  localparam int unsigned Aw   = 18;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [Aw-1:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

  int n_checks;
  int n_fail;

  sram_controller #(
    .BASE_ADDR(Base),
    .SRAM_AW  (Aw)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: registers mem[ADDR] every edge, drives DQ in the cycle
  // after WE_N=1, writes DQ on every edge where WE_N=0.
  logic [15:0] mem [0:(1<<Aw)-1];
  logic [15:0] sram_rdata;
  logic        sram_drv;
  logic        mem_clr;
  int          sram_writes;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << Aw); i++) mem[i] <= '0;
      sram_rdata  <= '0;
      sram_drv    <= 1'b0;
      sram_writes <= 0;
    end else begin
      if (SRAM_WE_N == 1'b0) begin
        mem[SRAM_ADDR] <= SRAM_DQ;
        sram_writes    <= sram_writes + 1;
      end
      sram_rdata <= mem[SRAM_ADDR];
      sram_drv   <= SRAM_WE_N;
    end
  end

  assign SRAM_DQ = sram_drv ? sram_rdata : 16'hzzzz;

  // Whenever the SRAM drives, the bus must carry exactly its value.
  logic mon_en;
  always @(negedge clk) begin
    if (mon_en && sram_drv) begin
      n_checks++;
      if (SRAM_DQ !== sram_rdata) begin
        n_fail++;
        $display("FAIL bus_contention t=%0t dq=%h required=%h", $time, SRAM_DQ, sram_rdata);
      end
    end
  end

  // Word-level reference model.
  logic [15:0] exp_mem [int];
  logic [31:0] exp_rd;

  function automatic int half_idx(input logic [31:0] addr);
    return int'(((addr - Base) >> 2) % (1 << (Aw - 1))) * 2;
  endfunction

  function automatic logic [15:0] exp_get(input int idx);
    if (exp_mem.exists(idx)) return exp_mem[idx];
    return 16'h0000;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int i;
    i = half_idx(addr);
    return {exp_get(i + 1), exp_get(i)};
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
    int i;
    i = half_idx(addr);
    exp_mem[i]     = data[15:0];
    exp_mem[i + 1] = data[31:16];
  endtask

  // Drives one request from an IDLE cycle (posedge+1) and returns the number
  // of ready-low cycles and read_data seen in the completing cycle.
  task automatic xfer(input bit wr, input bit rd, input logic [31:0] addr,
                      input logic [31:0] data, output int lows, output logic [31:0] rd_done);
    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = data;
    lows       = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) break;
      lows++;
    end
    rd_done = read_data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    mem_clr = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    address = '0;
    write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b0;
    mem_clr = 1'b0;
    exp_rd  = '0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b req=1", ready); end
    n_checks++;
    if (read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_read_data got=%h req=0", read_data);
    end
    n_checks++;
    if (SRAM_WE_N !== 1'b1) begin n_fail++; $display("FAIL reset_we_n got=%b req=1", SRAM_WE_N); end
    n_checks++;
    if (SRAM_ADDR !== '0) begin n_fail++; $display("FAIL reset_addr got=%h req=0", SRAM_ADDR); end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic test_write_read;
    int lows;
    logic [31:0] r;
    xfer(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lows, r);
    model_write(32'd1024, 32'hDEADBEEF);
    n_checks++;
    if (lows != 4) begin n_fail++; $display("FAIL wr_freeze got=%0d req=4", lows); end
    n_checks++;
    if (mem[0] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_mem0 got=%h req=beef", mem[0]); end
    n_checks++;
    if (mem[1] !== 16'hDEAD) begin n_fail++; $display("FAIL wr_mem1 got=%h req=dead", mem[1]); end
    n_checks++;
    if (r !== exp_rd) begin n_fail++; $display("FAIL wr_keeps_rd got=%h req=%h", r, exp_rd); end
    xfer(1'b0, 1'b1, 32'd1024, 32'h0, lows, r);
    exp_rd = model_read(32'd1024);
    n_checks++;
    if (lows != 4) begin n_fail++; $display("FAIL rd_freeze got=%0d req=4", lows); end
    n_checks++;
    if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h req=deadbeef", r); end
  endtask

  task automatic test_back_to_back;
    int lows0, lows1;
    logic [31:0] r;
    xfer(1'b1, 1'b0, 32'd1028, 32'h11112222, lows0, r);
    xfer(1'b1, 1'b0, 32'd1032, 32'h33334444, lows1, r);
    model_write(32'd1028, 32'h11112222);
    model_write(32'd1032, 32'h33334444);
    n_checks++;
    if (lows0 != 4 || lows1 != 4) begin
      n_fail++; $display("FAIL b2b_freeze got=%0d,%0d req=4,4", lows0, lows1);
    end
    for (int i = 2; i <= 5; i++) begin
      n_checks++;
      if (mem[i] !== exp_get(i)) begin
        n_fail++; $display("FAIL b2b_mem%0d got=%h req=%h", i, mem[i], exp_get(i));
      end
    end
  endtask

  task automatic test_both_requests;
    int lows;
    logic [31:0] r;
    xfer(1'b1, 1'b1, 32'd1036, 32'hA5A55A5A, lows, r);
    model_write(32'd1036, 32'hA5A55A5A);
    n_checks++;
    if (mem[6] !== 16'h5A5A) begin n_fail++; $display("FAIL both_mem6 got=%h req=5a5a", mem[6]); end
    n_checks++;
    if (mem[7] !== 16'hA5A5) begin n_fail++; $display("FAIL both_mem7 got=%h req=a5a5", mem[7]); end
    n_checks++;
    if (r !== exp_rd) begin n_fail++; $display("FAIL both_rd_kept got=%h req=%h", r, exp_rd); end
  endtask

  task automatic test_rd_wr_rd;
    int lows;
    logic [31:0] r;
    logic [31:0] old;
    old = model_read(32'd1024);
    xfer(1'b0, 1'b1, 32'd1024, 32'h0, lows, r);
    exp_rd = old;
    n_checks++;
    if (r !== old) begin n_fail++; $display("FAIL rwr_first got=%h req=%h", r, old); end
    xfer(1'b1, 1'b0, 32'd1024, 32'h0, lows, r);
    model_write(32'd1024, 32'h0);
    xfer(1'b0, 1'b1, 32'd1024, 32'h0, lows, r);
    exp_rd = model_read(32'd1024);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL rwr_second got=%h req=0", r); end
  endtask

  task automatic test_reset_mid_write;
    logic [15:0] old_hi;
    old_hi     = exp_get(9);
    wr_en      = 1'b1;
    address    = 32'd1040;
    write_data = 32'hCAFEF00D;
    @(posedge clk);  // into WR_LO_A
    @(posedge clk);  // into WR_LO_B
    #1;
    rst   = 1'b1;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_mem[8] = 16'hF00D;  // only the low halfword lands
    exp_rd     = '0;
    @(negedge clk);
    n_checks++;
    if (SRAM_WE_N !== 1'b1) begin n_fail++; $display("FAIL rstmid_we_n got=%b req=1", SRAM_WE_N); end
    n_checks++;
    if (read_data !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_read_data got=%h req=0", read_data);
    end
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b req=1", ready); end
    n_checks++;
    if (mem[8] !== 16'hF00D) begin n_fail++; $display("FAIL rstmid_lo got=%h req=f00d", mem[8]); end
    n_checks++;
    if (mem[9] !== old_hi) begin n_fail++; $display("FAIL rstmid_hi got=%h req=%h", mem[9], old_hi); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle;
    int w0;
    int bad;
    w0  = sram_writes;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready !== 1'b1 || SRAM_WE_N !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL idle_ctrl bad_cycles=%0d req=0", bad); end
    n_checks++;
    if (sram_writes != w0) begin
      n_fail++; $display("FAIL idle_writes got=%0d req=%0d", sram_writes - w0, 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    int lows;
    int op;
    logic [31:0] a, d, r;
    for (int n = 0; n < 30; n++) begin
      a  = Base + 4 * $urandom_range(0, 15);
      d  = $urandom;
      op = $urandom_range(0, 3);
      if (op == 1 || op == 2) begin
        xfer(1'b1, (op == 2), a, d, lows, r);
        model_write(a, d);
        n_checks++;
        if (r !== exp_rd) begin n_fail++; $display("FAIL rnd_wr_rd_kept got=%h req=%h", r, exp_rd); end
        n_checks++;
        if ({mem[half_idx(a) + 1], mem[half_idx(a)]} !== model_read(a)) begin
          n_fail++;
          $display("FAIL rnd_wr_mem a=%0d got=%h%h req=%h", a, mem[half_idx(a) + 1],
                   mem[half_idx(a)], model_read(a));
        end
      end else begin
        xfer(1'b0, 1'b1, a, d, lows, r);
        exp_rd = model_read(a);
        n_checks++;
        if (r !== exp_rd) begin n_fail++; $display("FAIL rnd_rd a=%0d got=%h req=%h", a, r, exp_rd); end
      end
      n_checks++;
      if (lows != 4) begin n_fail++; $display("FAIL rnd_freeze got=%0d req=4", lows); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_both_requests();
    test_rd_wr_rd();
    test_reset_mid_write();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the processor's MEM stage to the off-chip 16-bit SRAM. Converts one 32-bit word read or write request into a fixed sequence of two 16-bit SRAM accesses. Drives the SRAM control, address and bidirectional data pins. Holds `ready` low so the pipeline freezes until the word transfer completes.

## Interface
- `BASE_ADDR`, default 1024: first byte address of data memory. Processor addresses are offset by this value before mapping.
- `SRAM_AW`, default 18: SRAM halfword address width.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: word write request, held by the pipeline until `ready`.
- `rd_en` in 1: word read request, held until `ready`.
- `address` in 32: byte address, word aligned; bits [1:0] ignored.
- `write_data` in 32: write word, held with `wr_en`.
- `read_data` out 32: last word read; registered.
- `ready` out 1: high when no transfer is pending or the current one completes this cycle.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out `SRAM_AW`: SRAM halfword address.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1 each: tied 0.
- `SRAM_WE_N` out 1: write enable, active low.

## Operation
- Word offset `w = (address - BASE_ADDR) >> 2`, taken from the low `SRAM_AW-1` bits.
- Low halfword is at SRAM address `{w, 1'b0}`; high halfword is at `{w, 1'b1}`. Little-endian: `write_data[15:0]` goes to the even address.
- SRAM behaviour the controller is built around:
  - The SRAM registers `mem[ADDR]` at each edge.
  - It drives DQ in the cycle after any cycle with `WE_N` = 1.
  - It writes DQ at each edge where `WE_N` = 0.
- FSM states: IDLE, RD_LO, RD_HI, RD_CAP, WR_LO_A, WR_LO_B, WR_HI, DONE.
- IDLE:
  - `wr_en` goes to WR_LO_A; otherwise `rd_en` goes to RD_LO; otherwise stay.
  - If both are asserted, the write wins.
  - `WE_N` = 1, DQ released.
- RD_LO: ADDR = lo, `WE_N` = 1.
- RD_HI: ADDR = hi, `WE_N` = 1; `read_data[15:0]` <= DQ at the end of the cycle.
- RD_CAP: ADDR = hi, `WE_N` = 1; `read_data[31:16]` <= DQ at the end of the cycle.
- WR_LO_A:
  - ADDR = lo, `WE_N` = 0, DQ released. This is the turnaround cycle, because the SRAM is still driving.
  - The garbage write into lo is overwritten in the next cycle.
- WR_LO_B: ADDR = lo, `WE_N` = 0, DQ = `write_data[15:0]`.
- WR_HI: ADDR = hi, `WE_N` = 0, DQ = `write_data[31:16]`. No turnaround is needed because `WE_N` was already 0.
- DONE: `WE_N` = 1, DQ released, then IDLE unconditionally.
- `ready` is combinational: `(IDLE && !wr_en && !rd_en) || DONE`.
- DQ is driven by the controller only in WR_LO_B and WR_HI; high-Z in every other state.
- `read_data` holds its value across writes and idle cycles. It changes only in RD_HI and RD_CAP.

## Timing
- Request seen in IDLE at cycle 0; `ready` = 0 in cycles 0–3.
- DONE is reached at cycle 4: `ready` = 1, and for reads `read_data` is valid. The pipeline advances at the end of cycle 4.
- Both reads and writes therefore freeze the pipeline for 4 cycles.
- The next request is accepted in the IDLE cycle 5. Back-to-back transfers cost 5 cycles each.
- Write data is committed in SRAM by the end of WR_HI.
- A read issued immediately after a write returns the new data.
- Reset values:
  - state IDLE, `read_data` 0, `SRAM_WE_N` 1, `SRAM_ADDR` 0, DQ high-Z.
  - `ready` = 1 if no request is pending.
- Reset mid-transfer aborts the transfer at that edge:
  - A write may leave only the low halfword updated. Not recovered.
  - A read leaves `read_data` = 0.
- Requests dropped before DONE are a pipeline bug. The controller still completes the sequence and then returns to IDLE.

## Structure
- Shared memory-system package holds:
  - the state enum;
  - `BASE_ADDR` default, halfword width 16, word width 32;
  - the freeze length constant (4).
- Single flat module. The address map is one assignment, so no sub-module is warranted.
- The tri-state driver stays at the top of this module.

## Test plan
- Write 0xDEADBEEF at 1024, then read 1024:
  - SRAM[0] = 0xBEEF and SRAM[1] = 0xDEAD;
  - `read_data` = 0xDEADBEEF in the read's DONE;
  - `ready` low exactly 4 cycles each.
- Write 0x11112222 at 1028, then 0x33334444 at 1032, back-to-back:
  - SRAM[2..5] = 2222, 1111, 4444, 3333;
  - no DQ contention (never X on DQ while the controller drives).
- `wr_en` and `rd_en` both high with address 1036, data 0xA5A5_5A5A: write performed, SRAM[6] = 0x5A5A; `read_data` unchanged.
- Read 1024, then write 0x0 to 1024, then read 1024: first read returns the old value, second read returns 0.
- Assert `rst` during WR_LO_B of a write to 1040: next cycle IDLE, `SRAM_WE_N` = 1, DQ high-Z, `read_data` = 0, `ready` = 1.
- Idle 10 cycles with no request: `ready` constantly 1, `SRAM_WE_N` = 1, DQ high-Z, no SRAM writes.
